des_round_sequencer: RTL and testbench
======================================

Name: des_round_sequencer

Overview:
- Iterative DES round controller that time-shares one external combinational SP_block (48-bit S-box input to 32-bit P(S()) output) to run one Feistel round per clock.
- Runs ITERATIONS back-to-back 16-round encryptions with descrypt salt-modified expansion, as the descrypt core requires. The default of 25 iterations gives crypt(3) DES.
- Sits between the key-schedule unit, which supplies round subkeys by index, and the SP_block instance. Input/output blocks are in IP domain; IP/FP are applied outside this block.

Parameters:
- ITERATIONS, 25, number of chained 16-round DES encryptions per job (1..1023).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only while idle (busy=0)
- salt  in  12  descrypt salt, latched on accepted start
- block_in  in  64  initial L0||R0 (post-IP), latched on accepted start
- round_idx  out  4  current round number 0..15, to key schedule
- subkey  in  48  K(round_idx+1), combinational from key schedule, valid in same cycle
- sp_din  out  48  E'(R) xor subkey, to SP_block.Din
- sp_dout  in  32  SP_block.P_S, combinational response in same cycle
- busy  out  1  high while rounds execute
- done  out  1  one-cycle pulse, block_out valid
- block_out  out  64  R16||L16 of final iteration (pre-FP), held until next accepted start

Behaviour:
- Reset (rst=1 at edge): state IDLE; busy=0, done=0, round_idx=0, block_out=0, internal L/R/salt/iteration counter=0. sp_din=E'(0)^subkey, don't-care. rst has priority over start, in any state.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch L=block_in[63:32], R=block_in[31:0], salt; round=0, iter=0; go RUN. start=0 -> stay.
- RUN: each cycle is one round. E'(R) = standard DES E on R, where R[31] = DES bit 1 and E output bit 47 = DES bit 1. Then for i=0..11, if salt[i]=1, swap E bits (47-i) and (23-i).
- RUN datapath: sp_din = E'(R) ^ subkey. At the edge: L<=R, R<=L^sp_dout, round<=round+1 (mod 16).
- End of iteration (round==15 edge): the next iteration's input is the swapped preoutput, since IP(FP(x))=x. Effective registers: L<=L^sp_dout, R<=R (no swap on round 16); then, if iterations remain, start the next iteration with L0=new R16 and R0=new L16.
- Implementation choice: on the round-15 edge write L<=L^sp_dout with R unchanged (giving R16=L reg... ), or store the pair as-is; the bench checks only block_out and the cycle timing.
- Iteration counter increments on each round-15 edge. When iter==ITERATIONS-1 at round 15: block_out<=R16||L16; go DONE.
- DONE: done=1 for exactly this cycle, busy=0; unconditionally -> IDLE. A start here is ignored; it is accepted from IDLE on the next cycle.
- Timing: start accepted at edge T; round r of iteration k executes in cycle T+1+16k+r; busy=1 for exactly 16*ITERATIONS cycles; done pulses in cycle T+16*ITERATIONS+1.
- round_idx = round counter while RUN, 0 otherwise.
- start while busy or in DONE: ignored; salt/block_in changes are ignored after latch.
- Reset mid-RUN: abort the job, no done pulse, block_out=0.

Test Plan:
- Reset check: rst for 2 cycles mid-job -> busy=0, done=0, round_idx=0, block_out=0 next cycle; no done pulse.
- Single DES, ITERATIONS=1, salt=0, block_in=64'hCC00CCFF_F0AAF0AA, key-schedule model for key 133457799BBCDFF1:
  - round 0: sp_din=48'h6117BA866527; SP model returns 32'h234AA9BB.
  - done at T+17 with block_out=64'h0A4CD995_43423234 (FP gives 85E813540F0AB405).
- Descrypt, ITERATIONS=25, salt=0, block_in=0, key "test" schedule:
  - busy high exactly 400 cycles; done pulse once.
  - block_out matches the software crypt reference model pre-FP.
- Salt swap: salt=12'h001, R=0, subkey=0 -> sp_din=0. Salt=12'h001 with R=32'h00000001 -> E bit 47 and E bit 1 both 1 before swap; verify bits 47 and 23 are exchanged against the model. Sweep all 12 salt bits singly.
- Start while busy: pulse start with different block_in at T+5 -> ignored, result unchanged. Start during the DONE cycle -> ignored; start next cycle -> accepted.
- Back-to-back jobs: two jobs issued at the earliest legal cycles -> two done pulses 16*ITERATIONS+2 cycles apart. block_out is held between the pulses.

Source files
------------

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller. It runs one Feistel round per clock through an external SP block
// and chains ITERATIONS 16-round encryptions with a descrypt salt-modified expansion.
module des_round_sequencer #(
    parameter int ITERATIONS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] salt,
    input  logic [63:0] block_in,
    output logic [3:0]  round_idx,
    input  logic [47:0] subkey,
    output logic [47:0] sp_din,
    input  logic [31:0] sp_dout,
    output logic        busy,
    output logic        done,
    output logic [63:0] block_out
);
    localparam int IW = 10;
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [31:0]   l_reg;
    logic [31:0]   r_reg;
    logic [11:0]   salt_reg;
    logic [IW-1:0] iter;
    logic [47:0]   e_std;
    logic [47:0]   e_salt;
    logic [31:0]   l_next;

    // Standard DES E. Output bit 47 is DES bit 1, and r_reg[31] is DES bit 1.
    assign e_std = {r_reg[0], r_reg[31:27], r_reg[28:23], r_reg[24:19], r_reg[20:15],
                    r_reg[16:11], r_reg[12:7], r_reg[8:3], r_reg[4:0], r_reg[31]};

    // NOTE: the full default ahead of the loop leaves no bit unassigned on any path, so no latch is inferred.
    always_comb begin
        e_salt = e_std;
        for (int i = 0; i < 12; i++) begin
            if (salt_reg[i]) begin
                e_salt[47-i] = e_std[23-i];
                e_salt[23-i] = e_std[47-i];
            end
        end
    end

    assign sp_din = e_salt ^ subkey;
    assign l_next = l_reg ^ sp_dout;

    // NOTE: reset is sampled at the clock edge, and every state bit uses non-blocking assignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            round_idx <= 4'd0;
            iter      <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            salt_reg  <= '0;
            block_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        l_reg     <= block_in[63:32];
                        r_reg     <= block_in[31:0];
                        salt_reg  <= salt;
                        round_idx <= 4'd0;
                        iter      <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    round_idx <= round_idx + 4'd1;
                    if (round_idx == 4'd15) begin
                        // Round 16 does not swap, so (L,R) is now R16||L16. That is the final
                        // result and also the next iteration's L0/R0.
                        l_reg <= l_next;
                        iter  <= iter + IW'(1);
                        if (iter == LAST_ITER) begin
                            block_out <= {l_next, r_reg};
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        l_reg <= r_reg;
                        r_reg <= l_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_des_round_sequencer.sv
// Self-checking bench for des_round_sequencer. It has a behavioural DES/descrypt model, a key
// schedule model and an SP block model, and runs one single-DES instance and one 25-iteration instance.
module tb_des_round_sequencer;
    localparam int E_TBL [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                  16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_TBL [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a, start_b, busy_a, busy_b, done_a, done_b;
    logic [11:0] salt_a, salt_b;
    logic [63:0] blk_a, blk_b, out_a, out_b;
    logic [3:0]  round_idx_a, round_idx_b;
    logic [47:0] subkey_a, subkey_b, sp_din_a, sp_din_b;
    logic [31:0] sp_dout_a, sp_dout_b;
    logic [47:0] ks_a [16];
    logic [47:0] ks_b [16];
    logic [47:0] exp_sp [$];

    int          checks = 0, failures = 0;
    int          last_done_a = -1, last_done_b = -1;
    logic [63:0] prev_out_a = '0;
    logic [47:0] first_sp_a;
    logic [31:0] first_spo_a;

    function automatic logic [31:0] sp_f(input logic [47:0] x);
        logic [31:0] s_out, p;
        logic [5:0]  c;
        for (int b = 0; b < 8; b++) begin
            c = x[47-6*b -: 6];
            s_out[31-4*b -: 4] = 4'(SBOX[b][{c[5], c[0], c[4:1]}]);
        end
        for (int j = 0; j < 32; j++) p[31-j] = s_out[32-P_TBL[j]];
        return p;
    endfunction

    function automatic logic [47:0] e_salted(input logic [31:0] r, input logic [11:0] s);
        logic [47:0] e;
        logic        t;
        for (int j = 0; j < 48; j++) e[47-j] = r[32-E_TBL[j]];
        for (int i = 0; i < 12; i++) begin
            if (s[i]) begin
                t = e[47-i];
                e[47-i] = e[23-i];
                e[23-i] = t;
            end
        end
        return e;
    endfunction

    assign subkey_a  = ks_a[round_idx_a];
    assign subkey_b  = ks_b[round_idx_b];
    assign sp_dout_a = sp_f(sp_din_a);
    assign sp_dout_b = sp_f(sp_din_b);

    des_round_sequencer #(.ITERATIONS(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .salt(salt_a), .block_in(blk_a),
        .round_idx(round_idx_a), .subkey(subkey_a), .sp_din(sp_din_a), .sp_dout(sp_dout_a),
        .busy(busy_a), .done(done_a), .block_out(out_a));

    des_round_sequencer #(.ITERATIONS(25)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .salt(salt_b), .block_in(blk_b),
        .round_idx(round_idx_b), .subkey(subkey_b), .sp_din(sp_din_b), .sp_dout(sp_dout_b),
        .busy(busy_b), .done(done_b), .block_out(out_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic key_sched(input logic [63:0] key, input bit to_b);
        logic [47:0] k [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int j = 0; j < 56; j++) cd[55-j] = key[64-PC1[j]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int n = 0; n < SHIFTS[i]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[i][47-j] = cd[56-PC2[j]];
        end
        if (to_b) ks_b = k;
        else ks_a = k;
    endtask

    // Plain DES rounds with the swap on every round, then undo the last swap to get R16||L16.
    // That preoutput is the result and also the next iteration's input block.
    task automatic ref_model(input int iters, input logic [11:0] s, input logic [63:0] blk,
                             input bit use_b, output logic [63:0] res);
        logic [47:0] ks [16];
        logic [31:0] l, r, f;
        logic [47:0] x;
        if (use_b) ks = ks_b;
        else ks = ks_a;
        exp_sp.delete();
        l = blk[63:32];
        r = blk[31:0];
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < 16; i++) begin
                x = e_salted(r, s) ^ ks[i];
                exp_sp.push_back(x);
                f = sp_f(x);
                {l, r} = {r, l ^ f};
            end
            {l, r} = {r, l};
        end
        res = {l, r};
    endtask

    task automatic random_ks_a();
        for (int i = 0; i < 16; i++) ks_a[i] = 48'({$urandom, $urandom});
    endtask

    // Each call starts at the earliest legal cycle after the previous job on dut_a.
    task automatic job_a(input logic [11:0] s, input logic [63:0] blk, input int poke, input bit early);
        logic [63:0] exp_out;
        ref_model(1, s, blk, 1'b0, exp_out);
        if (early) begin
            start_a = 1'b1; salt_a = s; blk_a = blk;
        end
        @(negedge clk);
        check("a_done_one_cycle", done_a, 0);
        if (early) check("a_start_in_done_ignored", busy_a, 0);
        start_a = 1'b1; salt_a = s; blk_a = blk;
        @(negedge clk);
        start_a = 1'b0; salt_a = 12'($urandom); blk_a = {$urandom, $urandom};
        for (int r = 0; r < 16; r++) begin
            if (r == 0) begin
                first_sp_a  = sp_din_a;
                first_spo_a = sp_dout_a;
            end
            check($sformatf("a_busy_r%0d", r), busy_a, 1);
            check($sformatf("a_round_idx_r%0d", r), round_idx_a, r);
            check($sformatf("a_sp_din_r%0d", r), sp_din_a, exp_sp[r]);
            if (r == 8) check("a_block_out_held", out_a, prev_out_a);
            start_a = (r == poke);
            if (r == poke) blk_a = {$urandom, $urandom};
            @(negedge clk);
        end
        start_a = 1'b0;
        check("a_done", done_a, 1);
        check("a_busy_at_done", busy_a, 0);
        check("a_block_out", out_a, exp_out);
        if (last_done_a >= 0) check("a_done_spacing", cyc - last_done_a, 18);
        last_done_a = cyc;
        prev_out_a  = exp_out;
    endtask

    task automatic job_b(input logic [11:0] s, input logic [63:0] blk);
        logic [63:0] exp_out;
        int          n, busy_cnt;
        ref_model(25, s, blk, 1'b1, exp_out);
        @(negedge clk);
        check("b_done_one_cycle", done_b, 0);
        start_b = 1'b1; salt_b = s; blk_b = blk;
        @(negedge clk);
        start_b = 1'b0; salt_b = 12'($urandom); blk_b = {$urandom, $urandom};
        n = 0;
        busy_cnt = 0;
        while (done_b !== 1'b1 && n < 1000) begin
            if (busy_b) busy_cnt++;
            start_b = (n == 7);
            @(negedge clk);
            n++;
        end
        start_b = 1'b0;
        check("b_done_seen", done_b, 1);
        check("b_done_latency", n, 400);
        check("b_busy_cycles", busy_cnt, 400);
        check("b_busy_at_done", busy_b, 0);
        check("b_block_out", out_b, exp_out);
        if (last_done_b >= 0) check("b_done_spacing", cyc - last_done_b, 402);
        last_done_b = cyc;
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        start_a = 1'b0; salt_a = '0; blk_a = '0;
        start_b = 1'b0; salt_b = '0; blk_b = '0;
        for (int i = 0; i < 16; i++) begin
            ks_a[i] = '0;
            ks_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_round_idx_a", round_idx_a, 0);
        check("rst_block_out_a", out_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_block_out_b", out_b, 0);

        // Known single-DES vector, key 133457799BBCDFF1.
        key_sched(64'h133457799BBCDFF1, 1'b0);
        job_a(12'h000, 64'hCC00CCFF_F0AAF0AA, -1, 1'b0);
        check("known_sp_din_r0", first_sp_a, 48'h6117BA866527);
        check("known_sp_dout_r0", first_spo_a, 32'h234AA9BB);
        check("known_block_out", out_a, 64'h0A4CD995_43423234);

        // Salt swap with zero subkeys.
        for (int i = 0; i < 16; i++) ks_a[i] = '0;
        job_a(12'h001, 64'h0, -1, 1'b0);
        check("salt1_r0_zero", first_sp_a, 48'h0);
        job_a(12'h001, 64'h1, -1, 1'b0);
        check("salt1_r1_swap", first_sp_a, 48'h000000800002);
        for (int i = 0; i < 12; i++) begin
            random_ks_a();
            job_a(12'(1 << i), {$urandom, $urandom}, -1, 1'b0);
        end

        // Random jobs: a start pulse mid-run at T+5, and a start held through the DONE cycle.
        key_sched({$urandom, $urandom}, 1'b0);
        job_a(12'($urandom), {$urandom, $urandom}, 4, 1'b0);
        job_a(12'($urandom), {$urandom, $urandom}, -1, 1'b1);
        random_ks_a();
        job_a(12'($urandom), {$urandom, $urandom}, 4, 1'b1);
        job_a(12'($urandom), {$urandom, $urandom}, -1, 1'b0);

        // Descrypt with key "test", followed back-to-back by a random salt and block.
        key_sched(64'hE8CAE6E8_00000000, 1'b1);
        job_b(12'h000, 64'h0);
        job_b(12'($urandom), {$urandom, $urandom});

        // Reset in the middle of a job.
        @(negedge clk);
        start_b = 1'b1; salt_b = 12'($urandom); blk_b = {$urandom, $urandom};
        @(negedge clk);
        start_b = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_busy_b", busy_b, 0);
        check("midrst_done_b", done_b, 0);
        check("midrst_round_idx_b", round_idx_b, 0);
        check("midrst_block_out_b", out_b, 0);
        check("midrst_block_out_a", out_a, 0);
        dones = 0;
        for (int i = 0; i < 500; i++) begin
            if (done_b) dones++;
            @(negedge clk);
        end
        check("midrst_no_done", dones, 0);
        check("midrst_block_out_held", out_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
